// File: rtl/clkdiv_multi.sv
// clkdiv_multi
//   Multi-channel clock-enable generator. Each channel counts master clock
//   cycles modulo a runtime-programmable divisor D and decodes a one-cycle
//   enable strobe (tick) and a divided square wave (sq) from its registered
//   counter. The outputs are enables for fabric logic and are never used as
//   clocks.
//
//   New divisors are written into a per-channel shadow register and take
//   effect at the channel's next wrap, so a period is never cut short. A sync
//   pulse restarts every channel at cnt = 0 and applies any pending divisor.
//   D = 0 disables a channel: cnt is held at 0 and tick/sq stay low.
//
//   Build option CLKDIV_IMMEDIATE_LOAD_EN: when defined, a valid write loads
//   the divisor and clears the counter on the next edge regardless of phase,
//   and pend is tied low.
//
// Ports
//   clk     in   master clock
//   clr     in   asynchronous reset, active-high
//   wr_en   in   divisor write strobe (one cycle)
//   wr_ch   in   target channel of the write; indices >= NUM_CH are ignored
//   wr_div  in   new divisor value
//   sync    in   restart all channels together on the next edge
//   tick    out  per-channel one-cycle enable strobe (cnt == D-1)
//   sq      out  per-channel square wave, high for cnt >= ceil(D/2)
//   pend    out  per-channel flag: a written divisor is waiting to load
module clkdiv_multi #(
    parameter int                          NUM_CH     = 2,
    parameter int                          DIV_W      = 18,
    parameter logic [NUM_CH*DIV_W-1:0]     RESET_DIVS = {18'd131072, 18'd2}
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [DIV_W-1:0]  wr_div,
    input  logic              sync,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] pend
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [DIV_W-1:0] INIT_DIV = RESET_DIVS[g*DIV_W +: DIV_W];

        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] r_div;
        logic             w_hit;
        logic             w_en;
        logic             w_wrap;
        logic [DIV_W-1:0] w_half;

        // Only indices 0..NUM_CH-1 can match, so out-of-range writes fall
        // through with no effect.
        assign w_hit  = wr_en && (wr_ch == 3'(g));
        assign w_en   = (r_div != '0);
        assign w_wrap = w_en && (r_cnt == r_div - ONE);
        // ceil(D/2): odd divisors get the extra cycle in the low phase.
        assign w_half = {1'b0, r_div[DIV_W-1:1]} + {{(DIV_W-1){1'b0}}, r_div[0]};

        assign tick[g] = w_wrap;
        assign sq[g]   = (r_div >= TWO) && (r_cnt >= w_half);

`ifdef CLKDIV_IMMEDIATE_LOAD_EN
        assign pend[g] = 1'b0;

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                r_cnt <= '0;
                r_div <= INIT_DIV;
            end else if (w_hit) begin
                r_div <= wr_div;
                r_cnt <= '0;
            end else if (sync || w_wrap || !w_en) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + ONE;
            end
        end
`else
        logic [DIV_W-1:0] r_shadow;
        logic             r_pend;
        logic             w_load_pt;

        // Points where a new divisor may be applied: a wrap, a sync, or any
        // edge of a disabled channel that has something pending.
        assign w_load_pt = sync || w_wrap || (!w_en && r_pend);
        assign pend[g]   = r_pend;

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                r_cnt    <= '0;
                r_div    <= INIT_DIV;
                r_shadow <= INIT_DIV;
                r_pend   <= 1'b0;
            end else begin
                if (w_hit) begin
                    r_shadow <= wr_div;
                end
                if (w_load_pt) begin
                    // A write landing on a load point bypasses the shadow.
                    if (w_hit) begin
                        r_div <= wr_div;
                    end else if (r_pend) begin
                        r_div <= r_shadow;
                    end
                    r_pend <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    if (w_hit) begin
                        r_pend <= 1'b1;
                    end
                    r_cnt <= w_en ? r_cnt + ONE : '0;
                end
            end
        end
`endif
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
module tb_clkdiv_multi;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 18;

    logic              clk    = 1'b0;
    logic              clr    = 1'b1;
    logic              wr_en  = 1'b0;
    logic [2:0]        wr_ch  = 3'd0;
    logic [DIV_W-1:0]  wr_div = '0;
    logic              sync   = 1'b0;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] pend;

    clkdiv_multi #(
        .NUM_CH     (NUM_CH),
        .DIV_W      (DIV_W),
        .RESET_DIVS ({18'd131072, 18'd2})
    ) dut (
        .clk    (clk),
        .clr    (clr),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .sync   (sync),
        .tick   (tick),
        .sq     (sq),
        .pend   (pend)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      nm;
        int         c;
        logic [5:0] m;
        logic [5:0] e;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // layout: {pend1, pend0, sq1, sq0, tick1, tick0}
    always @(negedge clk) begin
        exp_t       x;
        logic [5:0] obs;
        obs = {pend, sq, tick};
        while (sbq.size() > 0 && sbq[0].c <= cyc) begin
            x = sbq.pop_front();
            total++;
            if (x.c != cyc) begin
                bad++;
                $display("FAIL %s stale entry: cycle=%0d now=%0d", x.nm, x.c, cyc);
            end else if ((obs & x.m) != (x.e & x.m)) begin
                bad++;
                $display("FAIL %s cycle=%0d got=%b required=%b", x.nm, cyc, obs & x.m, x.e & x.m);
            end
        end
    end

    function automatic logic [1:0] per(input int d, input int k);
        int c;
        if (d == 0) return 2'b00;
        c = k % d;
        return {(d >= 2) && (c >= (d + 1) / 2), c == d - 1};
    endfunction

    function automatic logic [5:0] vec(input logic [1:0] st0, input logic p0,
                                       input logic [1:0] st1, input logic p1);
        return {p1, p0, st1[1], st0[1], st1[0], st0[0]};
    endfunction

    task automatic push(input string nm, input int c, input logic [5:0] e);
        exp_t x;
        x.nm = nm;
        x.c  = c;
        x.m  = 6'h3f;
        x.e  = e;
        sbq.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 2000) begin
            step();
            n++;
        end
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout left=%0d required=0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic do_reset(output int r);
        clr = 1'b1;
        for (int i = 0; i < 3; i++) push("reset", cyc + i, 6'h00);
        steps(2);
        clr = 1'b0;
        r = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int w;
        step();

        // reset defaults, plus writes to channel indices that do not exist
        do_reset(r);
        for (int n = r + 1; n <= r + 30; n++)
            push("rst_dflt", n, vec(per(2, n - r), 1'b0, per(131072, n - r), 1'b0));
        steps(10);
        wr_en = 1'b1; wr_ch = 3'd5; wr_div = 18'd7;
        step();
        wr_ch = 3'd2; wr_div = 18'd1;
        step();
        wr_ch = 3'd7; wr_div = 18'd0;
        step();
        wr_en = 1'b0;
        drain();

        // odd divisor written at cnt 0 of D=2
        do_reset(r);
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 18'd5;
        push("odd_pend", r + 1, vec(2'b11, 1'b1, 2'b00, 1'b0));
        for (int n = r + 2; n <= r + 21; n++)
            push("odd_run", n, vec(per(5, n - r - 2), 1'b0, per(131072, n - r), 1'b0));
        step();
        wr_en = 1'b0;
        drain();

        // write landing on a wrap: bypass, pend never set
        do_reset(r);
        push("coll_tick", r + 1, vec(2'b11, 1'b0, 2'b00, 1'b0));
        for (int n = r + 2; n <= r + 17; n++)
            push("coll_run", n, vec(per(4, n - r - 2), 1'b0, per(131072, n - r), 1'b0));
        step();
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 18'd4;
        step();
        wr_en = 1'b0;
        drain();

        // disable with D=0, then re-enable with D=3
        do_reset(r);
        w = r + 6;
        push("dis_pend", r + 1, vec(2'b11, 1'b1, 2'b00, 1'b0));
        for (int n = r + 2; n <= w; n++)
            push("dis_idle", n, vec(2'b00, 1'b0, per(131072, n - r), 1'b0));
        push("reen_pend", w + 1, vec(2'b00, 1'b1, per(131072, w + 1 - r), 1'b0));
        for (int n = w + 2; n <= w + 14; n++)
            push("reen_run", n, vec(per(3, n - w - 2), 1'b0, per(131072, n - r), 1'b0));
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 18'd0;
        step();
        wr_en = 1'b0;
        steps(w - r - 1);
        wr_en = 1'b1; wr_div = 18'd3;
        step();
        wr_en = 1'b0;
        drain();

        // sync: load pending ch1, realign mid-count, then sync with a write
        do_reset(r);
        push("sync_pre0", r + 1, vec(2'b11, 1'b1, 2'b00, 1'b0));
        push("sync_pre1", r + 2, vec(2'b00, 1'b0, 2'b00, 1'b1));
        for (int n = r + 3; n <= r + 7; n++)
            push("sync_load", n, vec(per(3, n - r - 3), 1'b0, per(6, n - r - 3), 1'b0));
        for (int n = r + 8; n <= r + 20; n++)
            push("sync_align", n, vec(per(3, n - r - 8), 1'b0, per(6, n - r - 8), 1'b0));
        for (int n = r + 21; n <= r + 32; n++)
            push("sync_bypass", n, vec(per(3, n - r - 21), 1'b0, per(4, n - r - 21), 1'b0));
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 18'd3;
        step();
        wr_ch = 3'd1; wr_div = 18'd6;
        step();
        wr_en = 1'b0; sync = 1'b1;
        step();
        sync = 1'b0;
        steps(4);
        sync = 1'b1;
        step();
        sync = 1'b0;
        steps(12);
        wr_en = 1'b1; wr_ch = 3'd1; wr_div = 18'd4; sync = 1'b1;
        step();
        wr_en = 1'b0; sync = 1'b0;
        drain();

        // D=1: tick constantly high, sq constantly low
        do_reset(r);
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 18'd1;
        push("div1_pend", r + 1, vec(2'b11, 1'b1, 2'b00, 1'b0));
        for (int n = r + 2; n <= r + 8; n++)
            push("div1_run", n, vec(2'b01, 1'b0, per(131072, n - r), 1'b0));
        step();
        wr_en = 1'b0;
        drain();

        // asynchronous clr mid-count with a pending write
        do_reset(r);
        push("async_pre0", r + 1, vec(2'b11, 1'b1, 2'b00, 1'b0));
        push("async_pre1", r + 2, vec(per(5, 0), 1'b0, 2'b00, 1'b1));
        push("async_pre2", r + 3, vec(per(5, 1), 1'b0, 2'b00, 1'b1));
        push("async_pre3", r + 4, vec(per(5, 2), 1'b0, 2'b00, 1'b1));
        for (int n = r + 5; n <= r + 7; n++)
            push("async_clr", n, 6'h00);
        for (int n = r + 8; n <= r + 20; n++)
            push("async_post", n, vec(per(2, n - r - 7), 1'b0, per(131072, n - r - 7), 1'b0));
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 18'd5;
        step();
        wr_ch = 3'd1; wr_div = 18'd10;
        step();
        wr_en = 1'b0;
        steps(3);
        #2;
        clr = 1'b1;
        steps(2);
        clr = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
